decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Registered, parametrised RV32I/RV64I instruction-decode pipeline stage. Sits between the fetch stage and the register-file/execute stage. Splits each instruction into its fields and classifies it by format. Produces a single sign-extended XLEN-wide immediate, flags illegal encodings, and moves instructions with valid/ready handshakes on both sides. An optional skid buffer removes the combinational ready path.

Parameters:
XLEN, 32, datapath width (32 or 64); sets the immediate/PC width and the RV64-only legality rules.
SKID_EN, 1, 1 = two-entry output (output reg + skid reg) with registered in_ready; 0 = single output reg with combinational in_ready.
SUPPORT_M, 1, 1 = R-type func7 0000001 (M extension) is legal.

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
flush  input  1  discard all held and incoming instructions
in_valid  input  1  fetch presents instruction
in_ready  output  1  stage accepts instruction
in_inst  input  32  instruction word
in_pc  input  XLEN  instruction PC
out_valid  output  1  decoded bundle valid
out_ready  input  1  downstream accepts bundle
out_pc  output  XLEN  PC of the bundle
out_opcode  output  7  inst[6:0]
out_rd  output  5  inst[11:7]
out_rs1  output  5  inst[19:15]
out_rs2  output  5  inst[24:20]
out_func3  output  3  inst[14:12]
out_func7  output  7  inst[31:25]
out_imm  output  XLEN  sign-extended immediate
out_type  output  3  0=R 1=I 2=S 3=B 4=U 5=J
out_illegal  output  1  illegal encoding

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset: out_valid=0, skid empty, all out_* fields=0, in_ready=0 while rst is high. in_ready=1 from the first cycle after rst deasserts.
- Latency: 1 cycle. An input accepted at edge N is visible on out_* after edge N.
- Handshakes: a transfer occurs when valid&ready are both high at a clock edge.
- out_* must stay stable while out_valid=1 and out_ready=0.
- SKID_EN=0: in_ready = (~out_valid | out_ready) & ~flush.
- SKID_EN=1: in_ready = ~skid_valid & ~flush, driven only by state (no dependence on out_ready).
  - Input accepted while out_valid & ~out_ready → goes to the skid register.
  - When out_ready pops the output register, skid contents move to the output register on the same edge.
  - Order is strictly FIFO; no drop, no duplication.
- Simultaneous pop and accept with the skid empty: the new instruction loads the output register directly.
- Flush (highest priority below rst): on the flush edge, out_valid=0 and skid cleared.
  - The input is not accepted in that cycle (in_ready=0).
  - Field registers keep their values; only the valid bits clear.
- Field extraction: purely positional, as listed in Ports.
- Immediates (sign bit inst[31], extended to XLEN):
  - I: inst[31:20]
  - S: {inst[31:25],inst[11:7]}
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}
  - U: {inst[31:12],12'b0}
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}
  - R and illegal: 0
- Type by opcode:
  - 0110011 → R (plus 0111011 when XLEN=64)
  - 0010011, 0000011, 1100111, 1110011, 0001111 → I (plus 0011011 when XLEN=64)
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - any other opcode → illegal, type=0
- out_illegal=1 when any of the following holds:
  - inst[1:0]≠11, or unknown opcode
  - R: func7 ∉ {0000000, 0100000, 0000001 if SUPPORT_M}
  - R: func7=0100000 with func3 ∉ {000,101}
  - OP-IMM shifts, XLEN=32: func3=001 requires inst[31:25]=0; func3=101 requires inst[31:25] ∈ {0,0100000}
  - OP-IMM shifts, XLEN=64: same rules applied to inst[31:26]
  - Loads: func3 ∈ {011,110} legal only when XLEN=64; func3=111 always illegal
  - Stores: func3 > 010 (XLEN=32) or > 011 (XLEN=64)
  - Branches: func3 ∈ {010,011}
  - JALR: func3≠000
- Illegal instructions still flow through the stage with out_illegal=1; the trap is taken downstream.

Test Plan:
1. Reset, then in_inst=0xFFF10093 (addi x1,x2,-1), XLEN=32 → next cycle out_valid=1, rd=1, rs1=2, type=1, imm=0xFFFFFFFF, illegal=0.
2. Decode 0xFE000EE3 (beq x0,x0,-4) → type=3, imm=0xFFFFFFFC. Decode 0x001000EF (jal x1,2048) → type=5, rd=1, imm=0x00000800. Decode 0x123452B7 (lui x5) → type=4, imm=0x12345000 (XLEN=64: 0x0000000012345000).
3. Illegal encodings: 0x00000000 → illegal=1. 0x023100B3 (mul) with SUPPORT_M=0 → illegal=1; with SUPPORT_M=1 → illegal=0, type=0.
4. SKID_EN=1, out_ready=0, three back-to-back inputs A,B,C → A in output, B in skid, in_ready=0 so C is held. Raise out_ready → A, B, C emerge in order on consecutive cycles, none lost or duplicated.
5. Output and skid both full, flush pulsed 1 cycle with in_valid=1 → next cycle out_valid=0, in_ready=1; the flushed-cycle input is not later emitted.
6. rst asserted mid-stream with skid full → after the next edge, out_valid=0 and all fields=0. in_ready=0 while rst is high and returns to 1 on the cycle after release.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I instruction-decode pipeline stage.
//
// Splits each instruction into its positional fields. Classifies it by
// format (R/I/S/B/U/J). Produces one sign-extended XLEN-wide immediate and
// flags illegal encodings. Illegal instructions still flow through the stage;
// the trap is taken downstream.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   flush           drop every held and incoming instruction
//   in_valid/ready  fetch-side handshake; in_inst/in_pc are the payload
//   out_valid/ready execute-side handshake
//   out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_func3, out_func7
//                   registered instruction fields
//   out_imm         sign-extended immediate (0 for R type and unknown opcodes)
//   out_type        0=R 1=I 2=S 3=B 4=U 5=J
//   out_illegal     illegal encoding
//
// Parameters:
//   XLEN       32 or 64
//   SKID_EN    1: output reg + skid reg, in_ready comes only from state
//              0: single output reg, in_ready follows out_ready combinationally
//   SUPPORT_M  1: func7=0000001 (M extension) is a legal R-type encoding
module decode_stage #(
    parameter int XLEN      = 32,
    parameter bit SKID_EN   = 1'b1,
    parameter bit SUPPORT_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_func3,
    output logic [6:0]      out_func7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic            out_illegal
);

    localparam logic [2:0] TYPE_R = 3'd0;
    localparam logic [2:0] TYPE_I = 3'd1;
    localparam logic [2:0] TYPE_S = 3'd2;
    localparam logic [2:0] TYPE_B = 3'd3;
    localparam logic [2:0] TYPE_U = 3'd4;
    localparam logic [2:0] TYPE_J = 3'd5;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    localparam bit IS_RV64 = (XLEN == 64);

    // The raw word is kept so the positional fields come straight out of the
    // register; decode results that need logic are stored next to it.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] imm;
        logic [2:0]      itype;
        logic            illegal;
    } bundle_t;

    localparam int BUNDLE_W = $bits(bundle_t);

    bundle_t         dec_s;
    bundle_t         out_r;
    bundle_t         skid_r;
    logic            out_valid_r;
    logic            skid_valid_r;
    logic            accept_s;

    logic [6:0]      opc_s;
    logic [2:0]      f3_s;
    logic [6:0]      f7_s;
    logic [XLEN-1:0] imm_i_s;
    logic [XLEN-1:0] imm_s_s;
    logic [XLEN-1:0] imm_b_s;
    logic [XLEN-1:0] imm_u_s;
    logic [XLEN-1:0] imm_j_s;
    logic            r_bad_s;
    logic            sh_hi_zero_s;
    logic            sh_hi_sra_s;
    logic            opimm_bad_s;
    logic            load_bad_s;
    logic            store_bad_s;
    logic            branch_bad_s;

    assign opc_s = in_inst[6:0];
    assign f3_s  = in_inst[14:12];
    assign f7_s  = in_inst[31:25];

    // Size casts of signed operands sign-extend from inst[31] to XLEN.
    assign imm_i_s = XLEN'($signed(in_inst[31:20]));
    assign imm_s_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    assign imm_b_s = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                    in_inst[11:8], 1'b0}));
    assign imm_u_s = XLEN'($signed({in_inst[31:12], 12'b0}));
    assign imm_j_s = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                    in_inst[30:21], 1'b0}));

    assign r_bad_s = !((f7_s == 7'b0000000) ||
                       ((f7_s == 7'b0100000) && ((f3_s == 3'b000) || (f3_s == 3'b101))) ||
                       (SUPPORT_M && (f7_s == 7'b0000001)));

    // RV64 shift amounts are six bits wide, so only inst[31:26] is checked.
    assign sh_hi_zero_s = IS_RV64 ? (in_inst[31:26] == 6'b000000)
                                  : (in_inst[31:25] == 7'b0000000);
    assign sh_hi_sra_s  = IS_RV64 ? (in_inst[31:26] == 6'b010000)
                                  : (in_inst[31:25] == 7'b0100000);
    assign opimm_bad_s  = ((f3_s == 3'b001) && !sh_hi_zero_s) ||
                          ((f3_s == 3'b101) && !(sh_hi_zero_s || sh_hi_sra_s));

    assign load_bad_s   = (f3_s == 3'b111) ||
                          (!IS_RV64 && ((f3_s == 3'b011) || (f3_s == 3'b110)));
    assign store_bad_s  = IS_RV64 ? (f3_s > 3'b011) : (f3_s > 3'b010);
    assign branch_bad_s = (f3_s == 3'b010) || (f3_s == 3'b011);

    // Format classification, immediate selection and legality of the input word.
    // Any word with inst[1:0] != 11 has an opcode outside the list and lands
    // in the default branch.
    always_comb begin
        dec_s.pc      = in_pc;
        dec_s.inst    = in_inst;
        dec_s.imm     = {XLEN{1'b0}};
        dec_s.itype   = TYPE_R;
        dec_s.illegal = 1'b0;
        case (opc_s)
            OPC_OP: begin
                dec_s.illegal = r_bad_s;
            end
            OPC_OP_32: begin
                dec_s.illegal = IS_RV64 ? r_bad_s : 1'b1;
            end
            OPC_OP_IMM: begin
                dec_s.itype   = TYPE_I;
                dec_s.imm     = imm_i_s;
                dec_s.illegal = opimm_bad_s;
            end
            OPC_OP_IMM_32: begin
                if (IS_RV64) begin
                    dec_s.itype = TYPE_I;
                    dec_s.imm   = imm_i_s;
                end else begin
                    dec_s.illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                dec_s.itype   = TYPE_I;
                dec_s.imm     = imm_i_s;
                dec_s.illegal = load_bad_s;
            end
            OPC_JALR: begin
                dec_s.itype   = TYPE_I;
                dec_s.imm     = imm_i_s;
                dec_s.illegal = (f3_s != 3'b000);
            end
            OPC_SYSTEM, OPC_MISC_MEM: begin
                dec_s.itype = TYPE_I;
                dec_s.imm   = imm_i_s;
            end
            OPC_STORE: begin
                dec_s.itype   = TYPE_S;
                dec_s.imm     = imm_s_s;
                dec_s.illegal = store_bad_s;
            end
            OPC_BRANCH: begin
                dec_s.itype   = TYPE_B;
                dec_s.imm     = imm_b_s;
                dec_s.illegal = branch_bad_s;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_s.itype = TYPE_U;
                dec_s.imm   = imm_u_s;
            end
            OPC_JAL: begin
                dec_s.itype = TYPE_J;
                dec_s.imm   = imm_j_s;
            end
            default: begin
                dec_s.illegal = 1'b1;
            end
        endcase
    end

    // With the skid buffer, readiness depends only on skid occupancy, which
    // breaks the out_ready -> in_ready path.
    assign in_ready = !rst && !flush &&
                      (SKID_EN ? !skid_valid_r : (!out_valid_r || out_ready));
    assign accept_s = in_valid && in_ready;

    // Output/skid occupancy. The skid entry is always older than any new
    // input, so it refills the output slot first. On flush the payload
    // registers keep their contents and only the valid bits drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r        <= bundle_t'({BUNDLE_W{1'b0}});
            skid_r       <= bundle_t'({BUNDLE_W{1'b0}});
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (flush) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (!out_valid_r || out_ready) begin
            if (skid_valid_r) begin
                out_r        <= skid_r;
                out_valid_r  <= 1'b1;
                skid_valid_r <= 1'b0;
            end else if (accept_s) begin
                out_r       <= dec_s;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if (accept_s && SKID_EN) begin
            skid_r       <= dec_s;
            skid_valid_r <= 1'b1;
        end
    end

    assign out_valid   = out_valid_r;
    assign out_pc      = out_r.pc;
    assign out_opcode  = out_r.inst[6:0];
    assign out_rd      = out_r.inst[11:7];
    assign out_func3   = out_r.inst[14:12];
    assign out_rs1     = out_r.inst[19:15];
    assign out_rs2     = out_r.inst[24:20];
    assign out_func7   = out_r.inst[31:25];
    assign out_imm     = out_r.imm;
    assign out_type    = out_r.itype;
    assign out_illegal = out_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage. A driver issues directed and random
// instructions and queues the expected bundle of every accepted input. An
// independent monitor pops the queue on every output handshake. It also
// checks that the outputs hold steady during a stall.
module tb_decode_stage;

    localparam int XLEN      = 32;
    localparam bit SKID_EN   = 1'b1;
    localparam bit SUPPORT_M = 1'b1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_inst = 32'h0;
    logic [XLEN-1:0] in_pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_func3;
    logic [6:0]      out_func7;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_type;
    logic            out_illegal;

    decode_stage #(.XLEN(XLEN), .SKID_EN(SKID_EN), .SUPPORT_M(SUPPORT_M)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_func3(out_func3), .out_func7(out_func7), .out_imm(out_imm),
        .out_type(out_type), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Interpret the low `bits` bits of v as a two's-complement number.
    function automatic longint sext(input longint v, input int bits);
        longint m;
        m = v & ((longint'(1) <<< bits) - 1);
        if (((m >>> (bits - 1)) & 1) != 0) return m - (longint'(1) <<< bits);
        return m;
    endfunction

    function automatic logic [63:0] fit(input longint v);
        logic [63:0] r;
        r = v;
        if (XLEN == 32) r[63:32] = 32'h0;
        return r;
    endfunction

    // Reference decoder: a direct reading of the ISA tables using integer arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] inst, input logic [63:0] pc);
        exp_t   e;
        longint w, hi;
        int     op, f3, f7;
        bit     is64;
        is64 = (XLEN == 64);
        w  = longint'({32'h0, inst});
        op = int'(w & 127);
        f3 = int'((w >> 12) & 7);
        f7 = int'((w >> 25) & 127);
        e.inst = inst; e.pc = pc; e.imm = 64'h0; e.typ = 3'd0; e.ill = 1'b0;
        if ((op == 'h33) || (op == 'h3B && is64)) begin
            if (!(f7 == 0 || f7 == 32 || (SUPPORT_M && f7 == 1))) e.ill = 1'b1;
            if (f7 == 32 && !(f3 == 0 || f3 == 5)) e.ill = 1'b1;
        end else if (op == 'h13 || op == 'h03 || op == 'h67 || op == 'h73 ||
                     op == 'h0F || (op == 'h1B && is64)) begin
            e.typ = 3'd1;
            e.imm = fit(sext(w >> 20, 12));
            if (op == 'h13) begin
                hi = is64 ? (w >> 26) : (w >> 25);
                if (f3 == 1 && hi != 0) e.ill = 1'b1;
                if (f3 == 5 && hi != 0 && hi != (is64 ? 16 : 32)) e.ill = 1'b1;
            end
            if (op == 'h03 && (f3 == 7 || ((f3 == 3 || f3 == 6) && !is64))) e.ill = 1'b1;
            if (op == 'h67 && f3 != 0) e.ill = 1'b1;
        end else if (op == 'h23) begin
            e.typ = 3'd2;
            e.imm = fit(sext(((w >> 25) << 5) | ((w >> 7) & 31), 12));
            if (f3 > (is64 ? 3 : 2)) e.ill = 1'b1;
        end else if (op == 'h63) begin
            e.typ = 3'd3;
            e.imm = fit(sext((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                             (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1), 13));
            if (f3 == 2 || f3 == 3) e.ill = 1'b1;
        end else if (op == 'h37 || op == 'h17) begin
            e.typ = 3'd4;
            e.imm = fit(sext(w & 'hFFFFF000, 32));
        end else if (op == 'h6F) begin
            e.typ = 3'd5;
            e.imm = fit(sext((((w >> 31) & 1) << 20) | (((w >> 12) & 255) << 12) |
                             (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1), 21));
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    // Monitor: scoreboard pops on output handshakes, plus stall-stability tracking.
    logic        hold_prev = 1'b0;
    logic [63:0] snap_pc, snap_imm;
    logic [38:0] snap_flds;
    always @(negedge clk) begin
        exp_t e;
        if (hold_prev) begin
            chk("stall_valid", 64'(out_valid), 64'h1);
            chk("stall_pc", 64'(out_pc), snap_pc);
            chk("stall_imm", 64'(out_imm), snap_imm);
            chk("stall_fields", 64'({out_opcode, out_rd, out_rs1, out_rs2, out_func3,
                                     out_func7, out_type, out_illegal}), 64'(snap_flds));
        end
        if (!rst && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output_pc", 64'(out_pc), 64'hDEAD_0000_0000_BEEF);
            end else begin
                e = sb.pop_front();
                chk("pc", 64'(out_pc), e.pc);
                chk("opcode", 64'(out_opcode), 64'(e.inst[6:0]));
                chk("rd", 64'(out_rd), 64'(e.inst[11:7]));
                chk("rs1", 64'(out_rs1), 64'(e.inst[19:15]));
                chk("rs2", 64'(out_rs2), 64'(e.inst[24:20]));
                chk("func3", 64'(out_func3), 64'(e.inst[14:12]));
                chk("func7", 64'(out_func7), 64'(e.inst[31:25]));
                chk("imm", 64'(out_imm), e.imm);
                chk("type", 64'(out_type), 64'(e.typ));
                chk("illegal", 64'(out_illegal), 64'(e.ill));
            end
        end
        hold_prev = out_valid && !out_ready && !rst && !flush;
        snap_pc   = 64'(out_pc);
        snap_imm  = 64'(out_imm);
        snap_flds = {out_opcode, out_rd, out_rs1, out_rs2, out_func3, out_func7,
                     out_type, out_illegal};
    end

    // One clock of stimulus; queues the expected bundle if the input is accepted.
    task automatic step(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                        input logic ordy, input logic fl, input logic r);
        logic [63:0] pcx;
        @(posedge clk);
        #1;
        rst = r; flush = fl; in_valid = v; in_inst = inst;
        in_pc = pc[XLEN-1:0]; out_ready = ordy;
        @(negedge clk);
        #1;
        if (rst || flush) begin
            sb.delete();
        end else if (in_valid && in_ready) begin
            pcx = 64'h0;
            pcx[XLEN-1:0] = in_pc;
            sb.push_back(ref_decode(in_inst, pcx));
        end
    endtask

    task automatic kat(input string nm, input logic [31:0] inst, input logic [2:0] typ,
                       input logic [63:0] imm, input logic ill);
        step(1'b1, inst, 64'h2000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        chk({nm, "_valid"}, 64'(out_valid), 64'h1);
        chk({nm, "_type"}, 64'(out_type), 64'(typ));
        chk({nm, "_imm"}, 64'(out_imm), imm);
        chk({nm, "_illegal"}, 64'(out_illegal), 64'(ill));
    endtask

    task automatic chk_cleared(input string nm);
        chk({nm, "_valid"}, 64'(out_valid), 64'h0);
        chk({nm, "_pc"}, 64'(out_pc), 64'h0);
        chk({nm, "_imm"}, 64'(out_imm), 64'h0);
        chk({nm, "_fields"}, 64'({out_opcode, out_rd, out_rs1, out_rs2, out_func3,
                                  out_func7, out_type, out_illegal}), 64'h0);
    endtask

    function automatic logic [31:0] gen_inst();
        logic [31:0] w;
        logic [6:0]  ops [13];
        logic [6:0]  f7s [3];
        ops = '{7'h33, 7'h3B, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F,
                7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        f7s = '{7'h00, 7'h20, 7'h01};
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 12)];
        if ($urandom_range(0, 1) != 0) w[31:25] = f7s[$urandom_range(0, 2)];
        return w;
    endfunction

    initial begin
        logic        v, fl, ordy;
        logic [63:0] p;
        int          pct;

        // Reset state
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        chk_cleared("rst");

        // addi x1,x2,-1 straight after reset release
        step(1'b1, 32'hFFF10093, 64'h1000, 1'b0, 1'b0, 1'b0);
        chk("rel_in_ready", 64'(in_ready), 64'h1);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("addi_valid", 64'(out_valid), 64'h1);
        chk("addi_rd", 64'(out_rd), 64'h1);
        chk("addi_rs1", 64'(out_rs1), 64'h2);
        chk("addi_type", 64'(out_type), 64'h1);
        chk("addi_imm", 64'(out_imm), 64'hFFFF_FFFF);
        chk("addi_illegal", 64'(out_illegal), 64'h0);

        kat("beq", 32'hFE000EE3, 3'd3, 64'hFFFF_FFFC, 1'b0);
        kat("jal", 32'h001000EF, 3'd5, 64'h0000_0800, 1'b0);
        kat("lui", 32'h123452B7, 3'd4, 64'h1234_5000, 1'b0);
        kat("sw", 32'hFE112E23, 3'd2, 64'hFFFF_FFFC, 1'b0);
        kat("zero", 32'h00000000, 3'd0, 64'h0, 1'b1);
        kat("mul", 32'h023100B3, 3'd0, 64'h0, 1'b0);
        kat("jalr_f3", 32'h000010E7, 3'd1, 64'h0, 1'b1);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);

        // Skid: A, B, C back to back while downstream stalls
        step(1'b1, 32'h00100093, 64'hA0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00200113, 64'hB0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00300193, 64'hC0, 1'b0, 1'b0, 1'b0);
        chk("skid_full_in_ready", 64'(in_ready), 64'h0);
        chk("skid_head_pc", 64'(out_pc), 64'hA0);
        step(1'b1, 32'h00300193, 64'hC0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h00300193, 64'hC0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("skid_drained", 64'(sb.size()), 64'h0);

        // Flush with output and skid both full
        step(1'b1, 32'h00400213, 64'hD0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00500293, 64'hE0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00600313, 64'hF0, 1'b0, 1'b1, 1'b0);
        chk("flush_in_ready", 64'(in_ready), 64'h0);
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        chk("post_flush_valid", 64'(out_valid), 64'h0);
        chk("post_flush_in_ready", 64'(in_ready), 64'h1);
        repeat (3) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);

        // Reset mid-stream with the skid full
        step(1'b1, 32'h00700393, 64'h70, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00800413, 64'h80, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        chk("mid_rst_in_ready", 64'(in_ready), 64'h0);
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        chk_cleared("mid_rst");
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_release_in_ready", 64'(in_ready), 64'h1);

        // Random traffic: heavy back-pressure first, then mostly flowing
        for (int i = 0; i < 600; i++) begin
            pct  = (i < 300) ? 50 : 85;
            fl   = ($urandom_range(0, 39) == 0);
            ordy = fl ? 1'b0 : ($urandom_range(0, 99) < pct);
            v    = ($urandom_range(0, 3) != 0);
            p    = {$urandom, $urandom};
            step(v, gen_inst(), p, ordy, fl, 1'b0);
        end

        repeat (6) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("final_drained", 64'(sb.size()), 64'h0);
        chk("final_valid", 64'(out_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
